// File: rtl/cam_dvp_tx.sv
// DVP camera transmitter: frames an 8-bit byte stream into vsync/href/data timing.
// Define CAM_DVP_TX_PATTERN_EN to emit an internal column+line test pattern instead.
module cam_dvp_tx #(
    parameter int H_ACTIVE  = 64,
    parameter int H_BLANK   = 16,
    parameter int V_ACTIVE  = 32,
    parameter int VSYNC_CYC = 8,
    parameter int V_BACK    = 8,
    parameter int V_FRONT   = 8
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       enable,
    input  logic [7:0] pix_data,
    input  logic       pix_valid,
    output logic       pix_ready,
    output logic       cam_vsync,
    output logic       cam_href,
    output logic [7:0] cam_dat,
    output logic       frame_done,
    output logic       underrun,
    input  logic       underrun_clr
);

    typedef enum logic [2:0] {
        IDLE,
        VSYNC,
        VBACK,
        ACTIVE,
        HBLANK,
        VFRONT
    } state_e;

    localparam logic [11:0] HA_LAST = 12'(H_ACTIVE - 1);
    localparam logic [11:0] HB_LAST = 12'(H_BLANK - 1);
    localparam logic [11:0] VA_LAST = 12'(V_ACTIVE - 1);
    localparam logic [11:0] VS_LAST = 12'(VSYNC_CYC - 1);
    localparam logic [11:0] VB_LAST = 12'(V_BACK - 1);
    localparam logic [11:0] VF_LAST = 12'(V_FRONT - 1);

    state_e      state_q, state_d;
    logic [11:0] cnt_q, cnt_d;
    logic [11:0] col_q, col_d;
    logic [11:0] line_q, line_d;
    logic        vsync_q, vsync_d;
    logic        href_q, href_d;
    logic [7:0]  dat_q, dat_d;
    logic        done_q, done_d;
    logic        urun_q, urun_d;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (enable) state_d = VSYNC;
            end
            VSYNC: begin
                if (cnt_q == VS_LAST) state_d = VBACK;
            end
            VBACK: begin
                if (cnt_q == VB_LAST) state_d = ACTIVE;
            end
            ACTIVE: begin
                if (col_q == HA_LAST) state_d = HBLANK;
            end
            HBLANK: begin
                if (cnt_q == HB_LAST) begin
                    state_d = (line_q == VA_LAST) ? VFRONT : ACTIVE;
                end
            end
            VFRONT: begin
                if (cnt_q == VF_LAST) state_d = enable ? VSYNC : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // cnt times every fixed-length phase and restarts on each state change
    always_comb begin
        cnt_d  = cnt_q + 12'd1;
        col_d  = col_q;
        line_d = line_q;
        if (state_d != state_q || state_q == IDLE) begin
            cnt_d = '0;
        end
        if (state_q == IDLE) begin
            col_d  = '0;
            line_d = '0;
        end
        if (state_q == ACTIVE) begin
            col_d = (col_q == HA_LAST) ? 12'd0 : col_q + 12'd1;
        end
        if (state_q == HBLANK && cnt_q == HB_LAST) begin
            line_d = (line_q == VA_LAST) ? 12'd0 : line_q + 12'd1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q  <= '0;
            col_q  <= '0;
            line_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            col_q  <= col_d;
            line_q <= line_d;
        end
    end

    always_comb begin
        vsync_d = (state_q == VSYNC);
        href_d  = (state_q == ACTIVE);
        done_d  = (state_q == VFRONT) && (cnt_q == VF_LAST);
`ifdef CAM_DVP_TX_PATTERN_EN
        dat_d   = href_d ? (col_q[7:0] + line_q[7:0]) : 8'h00;
        urun_d  = 1'b0;
`else
        dat_d   = (href_d && pix_valid) ? pix_data : 8'h00;
        // a fresh underrun outranks a simultaneous clear
        urun_d  = (href_d && !pix_valid) | (urun_q & ~underrun_clr);
`endif
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            vsync_q <= 1'b0;
            href_q  <= 1'b0;
            dat_q   <= 8'h00;
            done_q  <= 1'b0;
            urun_q  <= 1'b0;
        end else begin
            vsync_q <= vsync_d;
            href_q  <= href_d;
            dat_q   <= dat_d;
            done_q  <= done_d;
            urun_q  <= urun_d;
        end
    end

`ifdef CAM_DVP_TX_PATTERN_EN
    logic unused_stream;
    assign unused_stream = ^{pix_data, pix_valid, underrun_clr};
    assign pix_ready     = 1'b0;
`else
    assign pix_ready     = (state_q == ACTIVE);
`endif

    assign cam_vsync  = vsync_q;
    assign cam_href   = href_q;
    assign cam_dat    = dat_q;
    assign frame_done = done_q;
    assign underrun   = urun_q;

endmodule

// File: tb/tb_cam_dvp_tx.sv
// Randomized scoreboard bench for cam_dvp_tx against a frame-position model.
module tb_cam_dvp_tx;

    localparam int HA = 4;
    localparam int HB = 2;
    localparam int VA = 3;
    localparam int VS = 2;
    localparam int VB = 3;
    localparam int VF = 1;
    localparam int FRAME = VS + VB + VA * (HA + HB) + VF;

    logic       clk = 1'b0;
    logic       resetn;
    logic       enable;
    logic [7:0] pix_data;
    logic       pix_valid;
    logic       pix_ready;
    logic       cam_vsync;
    logic       cam_href;
    logic [7:0] cam_dat;
    logic       frame_done;
    logic       underrun;
    logic       underrun_clr;

    always #5 clk = ~clk;

    cam_dvp_tx #(
        .H_ACTIVE (HA),
        .H_BLANK  (HB),
        .V_ACTIVE (VA),
        .VSYNC_CYC(VS),
        .V_BACK   (VB),
        .V_FRONT  (VF)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .enable      (enable),
        .pix_data    (pix_data),
        .pix_valid   (pix_valid),
        .pix_ready   (pix_ready),
        .cam_vsync   (cam_vsync),
        .cam_href    (cam_href),
        .cam_dat     (cam_dat),
        .frame_done  (frame_done),
        .underrun    (underrun),
        .underrun_clr(underrun_clr)
    );

    typedef struct packed {
        logic       vs;
        logic       hr;
        logic [7:0] dat;
        logic       fd;
        logic       ur;
        logic       rdy;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   m_idle = 1'b1;
    int   m_pos = 0;
    bit   m_ur = 1'b0;

    task automatic chk(input string nm, input logic [15:0] act,
                       input logic [15:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, req, $time);
        end
    endtask

    // 0 vsync, 1 back porch, 2 active byte, 3 hblank, 4 front porch
    function automatic int ph(input int p, output int col, output int ln);
        int q;
        col = 0;
        ln  = 0;
        if (p < VS) return 0;
        if (p < VS + VB) return 1;
        q = p - VS - VB;
        if (q < VA * (HA + HB)) begin
            ln  = q / (HA + HB);
            col = q % (HA + HB);
            return (col < HA) ? 2 : 3;
        end
        return 4;
    endfunction

    function automatic bit cur_active();
        int c, l;
        return !m_idle && ph(m_pos, c, l) == 2;
    endfunction

    task automatic model(input bit en, input bit v, input logic [7:0] d,
                         input bit clr);
        exp_t e;
        int   c, l, k;
        k = m_idle ? -1 : ph(m_pos, c, l);
        e.vs = (k == 0);
        e.hr = (k == 2);
        e.fd = !m_idle && m_pos == FRAME - 1;
`ifdef CAM_DVP_TX_PATTERN_EN
        e.dat = (k == 2) ? 8'(c + l) : 8'h00;
        e.ur  = 1'b0;
`else
        e.dat = (k == 2 && v) ? d : 8'h00;
        if (k == 2 && !v) m_ur = 1'b1;
        else if (clr) m_ur = 1'b0;
        e.ur = m_ur;
`endif
        if (m_idle) begin
            if (en) begin
                m_idle = 1'b0;
                m_pos  = 0;
            end
        end else if (m_pos == FRAME - 1) begin
            m_pos  = 0;
            m_idle = !en;
        end else begin
            m_pos++;
        end
`ifdef CAM_DVP_TX_PATTERN_EN
        e.rdy = 1'b0;
`else
        e.rdy = cur_active();
`endif
        sb.push_back(e);
    endtask

    task automatic step(input bit en, input bit v, input logic [7:0] d,
                        input bit clr);
        @(negedge clk);
        resetn       = 1'b1;
        enable       = en;
        pix_valid    = v;
        pix_data     = d;
        underrun_clr = clr;
        model(en, v, d, clr);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_vsync"}, cam_vsync, 1'b0);
        chk({tag, "_href"}, cam_href, 1'b0);
        chk({tag, "_dat"}, cam_dat, 8'h00);
        chk({tag, "_done"}, frame_done, 1'b0);
        chk({tag, "_urun"}, underrun, 1'b0);
        chk({tag, "_rdy"}, pix_ready, 1'b0);
    endtask

    task automatic run_until(input int tl, input int tc, input bit en);
        int  c, l, k;
        bit  hit;
        hit = 1'b0;
        for (int i = 0; i < 3 * FRAME && !hit; i++) begin
            k = m_idle ? -1 : ph(m_pos, c, l);
            if (k == 2 && l == tl && c == tc) hit = 1'b1;
            else step(en, 1'b1, 8'($urandom), 1'b0);
        end
        chk("sync_reached", hit, 1'b1);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            chk("vs_hr_excl", cam_vsync & cam_href, 1'b0);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("vsync", cam_vsync, e.vs);
                chk("href", cam_href, e.hr);
                chk("dat", cam_dat, e.dat);
                chk("frame_done", frame_done, e.fd);
                chk("underrun", underrun, e.ur);
                chk("pix_ready", pix_ready, e.rdy);
            end
        end
    end

    initial begin : driver
        logic [7:0] nb;
        int         c, l, k;
        bit         v, clr, act;
        resetn       = 1'b0;
        enable       = 1'b0;
        pix_valid    = 1'b0;
        pix_data     = 8'h00;
        underrun_clr = 1'b0;
        #2;
        check_zero("rst");
        @(negedge clk);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0);

        // continuous frames with an incrementing byte stream
        nb = 8'h10;
        repeat (2 * FRAME + 3) begin
            act = cur_active();
            step(1'b1, 1'b1, nb, 1'b0);
            if (act) nb++;
        end

        // directed underrun, clear, and clear racing a new underrun
        repeat (FRAME) begin
            k   = m_idle ? -1 : ph(m_pos, c, l);
            v   = !(k == 2 && ((l == 0 && c == 1) || (l == 2 && c == 2)));
            clr = (k == 2 && l == 1 && c == 0) || (k == 2 && l == 2 && c == 2);
            step(1'b1, v, 8'($urandom), clr);
        end

        repeat (6 * FRAME) begin
            step(1'b1, $urandom_range(0, 3) != 0, 8'($urandom),
                 $urandom_range(0, 7) == 0);
        end

        // enable dropped during line 1 must not cut the frame short
        run_until(1, 1, 1'b1);
        repeat (FRAME + 10) step(1'b0, 1'b1, 8'($urandom), 1'b0);

        // asynchronous reset in the middle of line 2
        run_until(2, 1, 1'b1);
        @(negedge clk);
        #2;
        resetn = 1'b0;
        #1;
        check_zero("arst");
        m_idle = 1'b1;
        m_pos  = 0;
        m_ur   = 1'b0;
        sb.push_back('0);
        @(negedge clk);
        sb.push_back('0);
        repeat (2 * FRAME + 4) begin
            step(1'b1, $urandom_range(0, 3) != 0, 8'($urandom),
                 $urandom_range(0, 7) == 0);
        end

        @(posedge clk);
        #2;
        chk("sb_drained", 16'(sb.size()), 16'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
